// File: rtl/lc3b_control_fsm_pkg.sv
// lc3b_types: opcode, ALU operation and control-state encodings shared by the LC-3b control FSM.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br  = 4'b0000,
        op_add = 4'b0001,
        op_and = 4'b0101,
        op_ldr = 4'b0110,
        op_str = 4'b0111,
        op_not = 4'b1001
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3
    } lc3b_aluop;

    typedef enum logic [3:0] {
        s_fetch1,
        s_fetch2,
        s_fetch3,
        s_decode,
        s_add,
        s_and,
        s_not,
        s_calc_addr,
        s_ldr1,
        s_ldr2,
        s_str1,
        s_str2,
        s_br,
        s_br_taken
    } lc3b_ctrl_state;

    // States that hold a memory request open until mem_resp.
    function automatic logic is_mem_state(lc3b_ctrl_state s);
        return s == s_fetch2 || s == s_ldr1 || s == s_str2;
    endfunction

endpackage

// File: rtl/lc3b_control_fsm_if.sv
// lc3b_control_fsm_if: memory request/response handshake between the control FSM and memory.
interface lc3b_control_fsm_if;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    logic       mem_resp;

    modport master (output mem_read, mem_write, mem_byte_enable, input mem_resp);
    modport slave  (input mem_read, mem_write, mem_byte_enable, output mem_resp);
endinterface

// File: rtl/lc3b_control_fsm.sv
// lc3b_control_fsm: Moore control FSM for the LC-3b mp0 datapath with a memory-stall watchdog.
module lc3b_control_fsm
    import lc3b_types::*;
#(
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  lc3b_opcode                  opcode,
    input  logic                        branch_enable,
    lc3b_control_fsm_if.master          mem,
    output logic                        load_pc,
    output logic                        load_ir,
    output logic                        load_regfile,
    output logic                        load_mar,
    output logic                        load_mdr,
    output logic                        load_cc,
    output logic                        pcmux_sel,
    output logic                        storemux_sel,
    output logic                        alumux_sel,
    output logic                        regfilemux_sel,
    output logic                        marmux_sel,
    output logic                        mdrmux_sel,
    output lc3b_aluop                   aluop,
    output logic                        mem_error
);

    localparam int CW = (STALL_LIMIT == 0) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);
    localparam logic WD_EN = (STALL_LIMIT != 0);

    lc3b_ctrl_state state, state_next;
    logic [CW-1:0]  cnt;
    logic           stall, abort;

    assign stall = is_mem_state(state) && !mem.mem_resp;
    // A response on the final allowed cycle completes normally instead of aborting.
    assign abort = WD_EN && stall && cnt == LIMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= s_fetch1;
            cnt       <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= (WD_EN && stall && !abort) ? cnt + 1'b1 : '0;
            mem_error <= mem_error | abort;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            s_fetch1:    state_next = s_fetch2;
            s_fetch2:    state_next = mem.mem_resp ? s_fetch3 : s_fetch2;
            s_fetch3:    state_next = s_decode;
            s_decode: begin
                case (opcode)
                    op_add:         state_next = s_add;
                    op_and:         state_next = s_and;
                    op_not:         state_next = s_not;
                    op_ldr, op_str: state_next = s_calc_addr;
                    op_br:          state_next = s_br;
                    default:        state_next = s_fetch1;
                endcase
            end
            s_calc_addr: state_next = (opcode == op_str) ? s_str1 : s_ldr1;
            s_ldr1:      state_next = mem.mem_resp ? s_ldr2 : s_ldr1;
            s_str1:      state_next = s_str2;
            s_str2:      state_next = mem.mem_resp ? s_fetch1 : s_str2;
            s_br:        state_next = branch_enable ? s_br_taken : s_fetch1;
            default:     state_next = s_fetch1;
        endcase
        if (abort)
            state_next = s_fetch1;
    end

    assign mem.mem_byte_enable = 2'b11;

    // Outputs are gated by rst_n so an in-flight request drops the moment reset asserts.
    always_comb begin
        load_pc        = 1'b0;
        load_ir        = 1'b0;
        load_regfile   = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_cc        = 1'b0;
        pcmux_sel      = 1'b0;
        storemux_sel   = 1'b0;
        alumux_sel     = 1'b0;
        regfilemux_sel = 1'b0;
        marmux_sel     = 1'b0;
        mdrmux_sel     = 1'b0;
        aluop          = alu_add;
        mem.mem_read   = 1'b0;
        mem.mem_write  = 1'b0;
        if (rst_n) begin
            case (state)
                s_fetch1: begin
                    load_mar = 1'b1;
                    load_pc  = 1'b1;
                end
                s_fetch2, s_ldr1: begin
                    mem.mem_read = 1'b1;
                    load_mdr     = 1'b1;
                end
                s_fetch3: load_ir = 1'b1;
                s_add, s_and, s_not: begin
                    aluop        = (state == s_and) ? alu_and : (state == s_not) ? alu_not : alu_add;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                end
                s_calc_addr: begin
                    alumux_sel = 1'b1;
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                end
                s_ldr2: begin
                    regfilemux_sel = 1'b1;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                end
                s_str1: begin
                    storemux_sel = 1'b1;
                    aluop        = alu_pass;
                    mdrmux_sel   = 1'b1;
                    load_mdr     = 1'b1;
                end
                s_str2: begin
                    storemux_sel  = 1'b1;
                    mem.mem_write = 1'b1;
                end
                s_br_taken: begin
                    pcmux_sel = 1'b1;
                    load_pc   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
